// File: rtl/des_round_ctrl.sv
// des_round_ctrl: iterative DES sequencer, one Feistel round per clock.
// Owns IP/FP, the L/R state, the PC-1/PC-2 key schedule and the round
// counter; the round function f itself is external and combinational.
//
// Ports (DES bit 1 is the MSB of every vector):
//   clk, rst_n            clock, asynchronous active-low reset
//   start_valid/ready     request handshake; ready is high only in IDLE
//   decrypt               0 = encrypt, 1 = decrypt, sampled at accept
//   block_in, key_in      64-bit block and key (key parity bits ignored)
//   f_r, f_k              R half and round subkey to the round function
//   f_out                 round-function result
//   out_valid/out_ready   result handshake; block_out held until taken
//   block_out             finished block after FP
//   busy, round           high while rounds run; current round 0..15
module des_round_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic        decrypt,
  input  logic [64:1] block_in,
  input  logic [64:1] key_in,
  output logic [32:1] f_r,
  output logic [48:1] f_k,
  input  logic [32:1] f_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [64:1] block_out,
  output logic        busy,
  output logic [4:1]  round
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  function automatic logic [64:1] ip_perm(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++)
      y[7'(64 - i)] = x[7'(65 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [64:1] fp_perm(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++)
      y[7'(64 - i)] = x[7'(65 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [56:1] pc1_perm(input logic [64:1] x);
    logic [56:1] y;
    y = '0;
    for (int unsigned i = 0; i < 56; i++)
      y[6'(56 - i)] = x[7'(65 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [48:1] pc2_perm(input logic [56:1] x);
    logic [48:1] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++)
      y[6'(48 - i)] = x[6'(57 - PC2_T[6'(i)])];
    return y;
  endfunction

  // Rotation of one 28-bit key half; "left" moves bits toward DES bit 1.
  function automatic logic [28:1] rot28(input logic [28:1] x, input logic right,
                                        input logic [1:0] n);
    logic [28:1] y;
    case ({right, n})
      3'b001:  y = {x[27:1], x[28]};
      3'b010:  y = {x[26:1], x[28:27]};
      3'b101:  y = {x[1], x[28:2]};
      3'b110:  y = {x[2:1], x[28:3]};
      default: y = x;
    endcase
    return y;
  endfunction

  state_t       r_state;
  state_t       w_state_nxt;
  logic [32:1]  r_l;
  logic [32:1]  r_r;
  logic [28:1]  r_c;
  logic [28:1]  r_d;
  logic         r_mode;
  logic [4:1]   r_round;
  logic [64:1]  r_block_out;
  logic [1:0]   w_shamt;
  logic [28:1]  w_c_rot;
  logic [28:1]  w_d_rot;
  logic         w_last;

  assign w_last = (r_round == 4'd15);

  // Decrypt walks the schedule backwards: C16 == C0, so round 0 uses the
  // PC-1 halves unrotated and later rounds undo the encrypt shifts in reverse.
  always_comb begin
    w_shamt = 2'd2;
    if (r_mode) begin
      if (r_round == 4'd0)
        w_shamt = 2'd0;
      else if (r_round == 4'd1 || r_round == 4'd8 || r_round == 4'd15)
        w_shamt = 2'd1;
    end else if (r_round == 4'd0 || r_round == 4'd1 || r_round == 4'd8 ||
                 r_round == 4'd15) begin
      w_shamt = 2'd1;
    end
  end

  assign w_c_rot = rot28(r_c, r_mode, w_shamt);
  assign w_d_rot = rot28(r_d, r_mode, w_shamt);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)      w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_mode      <= 1'b0;
      r_round     <= '0;
      r_block_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            {r_l, r_r} <= ip_perm(block_in);
            {r_c, r_d} <= pc1_perm(key_in);
            r_mode     <= decrypt;
            r_round    <= '0;
          end
        end
        S_RUN: begin
          r_l     <= r_r;
          r_r     <= r_l ^ f_out;
          r_c     <= w_c_rot;
          r_d     <= w_d_rot;
          // 15 + 1 wraps to 0, which is the required round value in DONE.
          r_round <= r_round + 4'd1;
          if (w_last)
            r_block_out <= fp_perm({r_l ^ f_out, r_r});
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign busy        = (r_state == S_RUN);
  assign out_valid   = (r_state == S_DONE);
  assign round       = r_round;
  assign block_out   = r_block_out;
  assign f_r         = busy ? r_r : '0;
  assign f_k         = busy ? pc2_perm({w_c_rot, w_d_rot}) : '0;

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Iterative DES sequencer that runs one 64-bit block through 16 Feistel rounds, one round per clock, over a shared combinational round-function datapath (`f` = expansion, key XOR, S-boxes and P). It owns the IP/FP permutations, the L/R state registers, the PC-1/PC-2 key schedule and the round counter. It exposes ready/valid handshakes on both sides. It sits between the system bus front-end and the team's combinational DES round logic, and adds a registered, multi-cycle encrypt/decrypt path.

## Interface
No parameters. All widths are fixed by DES.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_valid` in 1: request to process `block_in` with `key_in`.
- `start_ready` out 1: block accepts a request; combinational, equal to (state == IDLE).
- `decrypt` in 1: 0 = encrypt, 1 = decrypt; sampled only at accept.
- `block_in` in [64:1]: input block; bit 64 = DES bit 1.
- `key_in` in [64:1]: 64-bit key; the parity bits (DES bits 8,16,…,64) are ignored.
- `f_r` out [32:1]: R half driven to the round function.
- `f_k` out [48:1]: round subkey driven to the round function.
- `f_out` in [32:1]: round-function result; combinational from `f_r`/`f_k`.
- `out_valid` out 1: `block_out` holds a finished result.
- `out_ready` in 1: consumer takes the result.
- `block_out` out [64:1]: result, after FP.
- `busy` out 1: high in RUN.
- `round` out [4:1]: current round index, 0–15.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE → RUN** on `start_valid & start_ready`. At that edge:
  - L,R ← IP(`block_in`).
  - C,D ← PC-1(`key_in`).
  - mode ← `decrypt`; round ← 0.
- **RUN**, each cycle:
  - Rotated halves C',D' are formed combinationally from C,D.
  - `f_k` = PC-2(C',D'); `f_r` = R.
  - At the edge: L ← R; R ← L ^ `f_out`; C,D ← C',D'; round ← round+1.
- **Encrypt rotation:** left rotate by the shift table for rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- **Decrypt rotation:** right rotate. Amount is 0 at round 0, 1 at rounds 1, 8 and 15, and 2 otherwise. This yields K16…K1.
- **RUN → DONE** at the edge where round = 15:
  - `block_out` ← FP({L ^ `f_out`, R}); this is the final swap (R16‖L16).
  - `out_valid` ← 1; round ← 0.
- **DONE → IDLE** on `out_valid & out_ready`. `out_valid` ← 0. `block_out` holds its last value until the next completion.
- `start_valid` is ignored in RUN and DONE. `block_in`, `key_in` and `decrypt` may change freely after accept.
- In IDLE and DONE, `f_r` and `f_k` are driven to 0, for deterministic waveforms.
- `out_ready` is a don't-care outside DONE.

## Timing
- **Reset** (asynchronous assert, synchronous deassert by the system):
  - state = IDLE; L, R, C, D, `block_out` = 0.
  - `out_valid` = 0, `busy` = 0, `round` = 0.
  - `start_ready` = 1 and `f_r` = `f_k` = 0 during and after reset.
- **Latency:** the accept edge is edge 0. Rounds execute on edges 1..16. `out_valid` is high after edge 16.
- **Throughput:** with `out_ready` tied high, `out_valid` is high for 1 cycle, IDLE is re-entered at edge 17, and the next accept is at the earliest on edge 18. The minimum issue interval is 18 cycles.
- **Backpressure:** `out_valid` and `block_out` are held stable indefinitely while `out_ready` = 0.
- **Reset mid-operation:** the operation is aborted and no result is produced. All outputs return to their reset values immediately, without waiting for a clock edge.
- **Critical path:** the external `f` logic sits between the R/C/D registers and the R register. `f_out` must settle within one cycle.

## Test plan
The bench instantiates the team's combinational round function on `f_r`/`f_k`/`f_out`.
- Encrypt, key 133457799BBCDFF1, block 0123456789ABCDEF -> `block_out` = 85E813540F0AB405. `out_valid` rises exactly 16 cycles after accept; `round` steps 0..15 while `busy` = 1.
- Decrypt, same key, block 85E813540F0AB405 -> `block_out` = 0123456789ABCDEF.
- Encrypt, key 0000000000000000, block 0000000000000000 -> 8CA64DE9C1B123A7. Repeat with key 12355678 9ABDDEF0 (parity bits of 133457799BBCDFF1 flipped) and block 0123456789ABCDEF -> 85E813540F0AB405.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE -> `out_valid` = 1, `block_out` constant, `start_ready` = 0. Pulse `start_valid` with a new block during DONE -> the request is ignored and not processed later.
- Reset mid-operation: assert `rst_n` = 0 at round 7 -> `busy` = 0, `out_valid` = 0, `block_out` = 0, `start_ready` = 1 asynchronously. A following encrypt of 0123456789ABCDEF returns 85E813540F0AB405.
- Back-to-back: `start_valid` held high with `out_ready` = 1 -> accepts occur every 18 cycles with correct alternating encrypt/decrypt results.
